universal_shift_register: RTL and testbench

- Parametrised successor to the team's fixed 4-bit load/clear register with on-board slow clock.
- Generalised data width and divider ratio.
- Adds shift, shift-right and rotate modes, with the shift/rotate step paced by an internal divided tick.
- Used in board demos where register contents must visibly step at a human-readable rate (LEDs), with the slow clock exported.

---
 rtl/universal_shift_register.sv | 104 ++++++++++
 tb/tb_universal_shift_register.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load, shift/rotate stepped by an internal divided tick.
// Build with USR_PARITY_EN defined to get a registered even-parity output; otherwise parity is tied 0.
module universal_shift_register #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50000000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tick,
    output logic             clk_slow,
    output logic             parity
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_SHL  = 2'b01,
        M_SHR  = 2'b10,
        M_ROL  = 2'b11
    } mode_e;

    logic [CW-1:0]    cnt;
    logic             wrap;
    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;

    assign wrap = (cnt == CNT_LAST);

    // Divider runs free of sclr/load/mode; only clr resets it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= '0;
            tick     <= 1'b0;
            clk_slow <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            tick <= wrap;
            if (wrap)
                clk_slow <= ~clk_slow;
        end
    end

    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        if (sclr) begin
            q_nxt    = '0;
            sout_nxt = 1'b0;
        end else if (load) begin
            q_nxt = d;
        end else if (tick) begin
            unique case (mode_e'(mode))
                M_SHL: begin
                    q_nxt    = {q[WIDTH-2:0], sin};
                    sout_nxt = q[WIDTH-1];
                end
                M_SHR: begin
                    q_nxt    = {sin, q[WIDTH-1:1]};
                    sout_nxt = q[0];
                end
                M_ROL: begin
                    q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_nxt = q[WIDTH-1];
                end
                default: begin
                    q_nxt    = q;
                    sout_nxt = sout;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q    <= '0;
            sout <= 1'b0;
        end else begin
            q    <= q_nxt;
            sout <= sout_nxt;
        end
    end

`ifdef USR_PARITY_EN
    // Computed from q_nxt so parity lines up with q on the same cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            parity <= 1'b0;
        else
            parity <= ^q_nxt;
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor retires them.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sclr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic [1:0] mode = 2'b00;
    logic       sin = 1'b0;
    logic [3:0] q;
    logic       sout, tick, clk_slow, parity;

    universal_shift_register #(.WIDTH(4), .DIV(4)) dut (
        .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d), .mode(mode), .sin(sin),
        .q(q), .sout(sout), .tick(tick), .clk_slow(clk_slow), .parity(parity)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         sel;   // 0 q, 1 sout, 2 tick, 3 clk_slow, 4 parity
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_exp(input int c, input int s, input logic [3:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.sel = s; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] pick(input int s);
        case (s)
            0:       return q;
            1:       return {3'b0, sout};
            2:       return {3'b0, tick};
            3:       return {3'b0, clk_slow};
            default: return {3'b0, parity};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [3:0] act;
                act = pick(sb[i].sel);
                n_vec++;
                if (act !== sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got %b want %b", sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        // reset held, then released after edge 2: ticks visible at cycles 6,10,...; steps at 7,11,...
        push_exp(1, 0, 4'b0000, "rst_q");
        push_exp(1, 1, 4'b0000, "rst_sout");
        push_exp(1, 2, 4'b0000, "rst_tick");
        push_exp(1, 3, 4'b0000, "rst_clk_slow");
        push_exp(5, 2, 4'b0000, "tick_c5");
        push_exp(6, 2, 4'b0001, "tick_c6");
        push_exp(7, 2, 4'b0000, "tick_c7");
        push_exp(10, 2, 4'b0001, "tick_c10");
        push_exp(5, 3, 4'b0000, "slow_c5");
        push_exp(6, 3, 4'b0001, "slow_c6");
        push_exp(9, 3, 4'b0001, "slow_c9");
        push_exp(10, 3, 4'b0000, "slow_c10");
        push_exp(14, 3, 4'b0001, "slow_c14");
        wait_cyc(2);
        clr = 1'b1;

        // load 1011, shift left sin=0
        wait_cyc(7);
        load = 1'b1; d = 4'b1011; mode = 2'b01; sin = 1'b0;
        push_exp(8, 0, 4'b1011, "shl_load");
        push_exp(10, 0, 4'b1011, "shl_hold_nontick");
        push_exp(11, 0, 4'b0110, "shl_step1");
        push_exp(11, 1, 4'b0001, "shl_sout1");
        push_exp(14, 0, 4'b0110, "shl_hold2");
        push_exp(15, 0, 4'b1100, "shl_step2");
        push_exp(15, 1, 4'b0000, "shl_sout2");
`ifdef USR_PARITY_EN
        push_exp(8, 4, 4'b0001, "par_1011");
        push_exp(11, 4, 4'b0000, "par_0110");
`else
        push_exp(8, 4, 4'b0000, "par_off_c8");
        push_exp(11, 4, 4'b0000, "par_off_c11");
`endif
        wait_cyc(8);
        n_vec++;
        if (q !== 4'b1011) begin
            n_err++;
            $display("FAIL direct shl_load: got %b want 1011", q);
        end
        load = 1'b0;

        // rotate left from 1011
        wait_cyc(15);
        load = 1'b1; d = 4'b1011; mode = 2'b11;
        push_exp(16, 0, 4'b1011, "rol_load");
        push_exp(19, 0, 4'b0111, "rol_step1");
        push_exp(19, 1, 4'b0001, "rol_sout1");
        push_exp(23, 0, 4'b1110, "rol_step2");
        push_exp(23, 1, 4'b0000, "rol_sout2");
        push_exp(27, 0, 4'b1101, "rol_step3");
        push_exp(27, 1, 4'b0001, "rol_sout3");
        push_exp(31, 0, 4'b1011, "rol_step4");
        push_exp(31, 1, 4'b0001, "rol_sout4");
        wait_cyc(16);
        n_vec++;
        if (q !== 4'b1011) begin
            n_err++;
            $display("FAIL direct rol_load: got %b want 1011", q);
        end
        load = 1'b0;

        // shift right from 1000, sin=1
        wait_cyc(31);
        load = 1'b1; d = 4'b1000; mode = 2'b10; sin = 1'b1;
        push_exp(32, 0, 4'b1000, "shr_load");
        push_exp(35, 0, 4'b1100, "shr_step1");
        push_exp(35, 1, 4'b0000, "shr_sout1");
        push_exp(39, 0, 4'b1110, "shr_step2");
        push_exp(39, 1, 4'b0000, "shr_sout2");
        wait_cyc(32);
        n_vec++;
        if (q !== 4'b1000) begin
            n_err++;
            $display("FAIL direct shr_load: got %b want 1000", q);
        end
        load = 1'b0;

        // load coincident with a step edge: load wins, sout untouched
        wait_cyc(42);
        load = 1'b1; d = 4'b0101; mode = 2'b01; sin = 1'b1;
        push_exp(43, 0, 4'b0101, "load_wins_q");
        push_exp(43, 1, 4'b0000, "load_wins_sout");
        push_exp(47, 0, 4'b1011, "post_load_step");
        push_exp(47, 1, 4'b0000, "post_load_sout");
        wait_cyc(43);
        n_vec++;
        if (q !== 4'b0101) begin
            n_err++;
            $display("FAIL direct load_wins: got %b want 0101", q);
        end
        load = 1'b0;

        // sclr beats load
        wait_cyc(48);
        sclr = 1'b1; load = 1'b1; d = 4'b1111;
        push_exp(49, 0, 4'b0000, "sclr_wins_q");
        push_exp(49, 1, 4'b0000, "sclr_wins_sout");
        wait_cyc(49);
        n_vec++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL direct sclr_wins: got %b want 0000", q);
        end
        sclr = 1'b0; load = 1'b0; mode = 2'b01; sin = 1'b1;

        // mode changed back to hold before the step edge: only step-edge mode counts
        wait_cyc(50);
        mode = 2'b00;
        push_exp(51, 0, 4'b0000, "hold_on_step");
        wait_cyc(51);
        mode = 2'b01;
        push_exp(55, 0, 4'b0001, "shl_sin1");
`ifndef USR_PARITY_EN
        push_exp(55, 4, 4'b0000, "par_off_c55");
`endif

        // async reset mid-run, between edges
        wait_cyc(57);
        #1;
        clr = 1'b0;
        push_exp(57, 0, 4'b0000, "async_q");
        push_exp(57, 2, 4'b0000, "async_tick");
        push_exp(57, 3, 4'b0000, "async_clk_slow");
        wait_cyc(59);
        clr = 1'b1;
        push_exp(62, 2, 4'b0000, "rel_tick_c62");
        push_exp(63, 2, 4'b0001, "rel_tick_c63");
        push_exp(64, 2, 4'b0000, "rel_tick_c64");
        push_exp(67, 2, 4'b0001, "rel_tick_c67");
        push_exp(66, 3, 4'b0001, "rel_slow_c66");
        push_exp(67, 3, 4'b0000, "rel_slow_c67");
        push_exp(71, 3, 4'b0001, "rel_slow_c71");

        wait_cyc(75);
        @(negedge clk);
        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: never sampled (cyc %0d) want %b", sb[0].name, sb[0].cyc, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
